// File: rtl/ram_bist.sv
// ram_bist: a two-pass write/read self-test for a 32 x 3-bit RAM.
// Pass 0 writes addr[2:0] to every location and reads it back. Pass 1 does the
// same with the inverted pattern. Mismatches are counted and saturate at 64.
// The RAM read data is expected READ_LAT cycles after the address changes.
// Optional feature macro: RAM_BIST_ERRLOG_EN. It adds first-error capture
// outputs: first_err_addr, first_err_data and first_err_pass.
module ram_bist #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [4:0] Address,
    output logic [2:0] DataIn,
    output logic       Write,
    input  logic [2:0] DataOut,
    output logic       busy,
    output logic       done,
    output logic       fail,
`ifdef RAM_BIST_ERRLOG_EN
    output logic [4:0] first_err_addr,
    output logic [2:0] first_err_data,
    output logic [0:0] first_err_pass,
`endif
    output logic [6:0] err_count
);

    // The wait counter must be able to hold the value READ_LAT.
    localparam int W_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [W_W-1:0] LAT_W = W_W'(READ_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_pass;
    logic [4:0]     r_addr;
    logic [W_W-1:0] r_w;
    logic           r_write;
    logic [2:0]     r_data_in;
    logic           r_busy;
    logic           r_done;
    logic           r_fail;
    logic [6:0]     r_err_count;
`ifdef RAM_BIST_ERRLOG_EN
    logic [4:0]     r_fe_addr;
    logic [2:0]     r_fe_data;
    logic           r_fe_pass;
`endif

    // Test pattern: the low address bits, inverted on the second pass.
    function automatic logic [2:0] pat(input logic [4:0] a, input logic p);
        return p ? ~a[2:0] : a[2:0];
    endfunction

    logic [2:0] w_expected;
    logic       w_mismatch;
    logic       w_read_now;
    logic       w_last_addr;
    logic       w_err_inc;
    logic [6:0] w_err_next;

    assign w_expected  = pat(r_addr, r_pass);
    assign w_mismatch  = (DataOut != w_expected);
    assign w_read_now  = (r_w == LAT_W);
    assign w_last_addr = (r_addr == 5'd31);
    // Saturate at 64; a run makes exactly 64 compares, so this never clips a
    // real count but keeps the counter from wrapping if the limit ever changes.
    assign w_err_inc   = w_mismatch && (r_err_count < 7'd64);
    assign w_err_next  = r_err_count + {6'd0, w_err_inc};

    assign Address   = r_addr;
    assign DataIn    = r_data_in;
    assign Write     = r_write;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign err_count = r_err_count;
`ifdef RAM_BIST_ERRLOG_EN
    assign first_err_addr    = r_fe_addr;
    assign first_err_data    = r_fe_data;
    assign first_err_pass[0] = r_fe_pass;
`endif

    // Sequencer: walks WRITE and READ twice, producing registered RAM controls.
    // r_addr is kept at 0 outside a run, so it drives Address directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pass      <= 1'b0;
            r_addr      <= 5'd0;
            r_w         <= '0;
            r_write     <= 1'b0;
            r_data_in   <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_err_count <= 7'd0;
`ifdef RAM_BIST_ERRLOG_EN
            r_fe_addr   <= 5'd0;
            r_fe_data   <= 3'd0;
            r_fe_pass   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= WRITE;
                        r_pass      <= 1'b0;
                        r_addr      <= 5'd0;
                        r_w         <= '0;
                        r_write     <= 1'b1;
                        r_data_in   <= pat(5'd0, 1'b0);
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_err_count <= 7'd0;
`ifdef RAM_BIST_ERRLOG_EN
                        r_fe_addr   <= 5'd0;
                        r_fe_data   <= 3'd0;
                        r_fe_pass   <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (w_last_addr) begin
                        r_state   <= READ;
                        r_addr    <= 5'd0;
                        r_w       <= '0;
                        r_write   <= 1'b0;
                        r_data_in <= 3'd0;
                    end else begin
                        r_addr    <= r_addr + 5'd1;
                        r_data_in <= pat(r_addr + 5'd1, r_pass);
                    end
                end
                READ: begin
                    if (w_read_now) begin
                        r_w         <= '0;
                        r_err_count <= w_err_next;
`ifdef RAM_BIST_ERRLOG_EN
                        // Capture only the first mismatch of the run.
                        if (w_mismatch && (r_err_count == 7'd0)) begin
                            r_fe_addr <= r_addr;
                            r_fe_data <= DataOut;
                            r_fe_pass <= r_pass;
                        end
`endif
                        if (w_last_addr) begin
                            r_addr <= 5'd0;
                            if (!r_pass) begin
                                r_state   <= WRITE;
                                r_pass    <= 1'b1;
                                r_write   <= 1'b1;
                                r_data_in <= pat(5'd0, 1'b1);
                            end else begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_fail  <= (w_err_next != 7'd0);
                            end
                        end else begin
                            r_addr <= r_addr + 5'd1;
                        end
                    end else begin
                        r_w <= r_w + W_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist with a behavioural RAM (one-cycle read latency) that can
// inject several fault types, plus a cycle-level reference model of the run.
module tb_ram_bist;

    localparam int LAT      = 1;
    localparam int PASS_LEN = 32 + 32 * (LAT + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] Address;
    logic [2:0] DataIn;
    logic       Write;
    logic [2:0] DataOut;
    logic       busy;
    logic       done;
    logic       fail;
    logic [6:0] err_count;
`ifdef RAM_BIST_ERRLOG_EN
    logic [4:0] first_err_addr;
    logic [2:0] first_err_data;
    logic [0:0] first_err_pass;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // 0: fault-free, 1: address 5 bit0 stuck-at-0, 2: writes ignored, reads 000,
    // 3: reads return the inverse of the stored value
    int ram_mode = 0;
    logic [2:0] mem [32];

    always #5 clk = ~clk;

    ram_bist #(.READ_LAT(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .Address(Address),
        .DataIn(DataIn),
        .Write(Write),
        .DataOut(DataOut),
        .busy(busy),
        .done(done),
        .fail(fail),
`ifdef RAM_BIST_ERRLOG_EN
        .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .first_err_pass(first_err_pass),
`endif
        .err_count(err_count)
    );

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 3'd0;
        DataOut = 3'd0;
    end

    // Behavioural RAM with a registered read port.
    always @(posedge clk) begin
        logic [2:0] v;
        v = mem[Address];
        if (Write && ram_mode != 2) mem[Address] <= DataIn;
        case (ram_mode)
            1:       DataOut <= (Address == 5'd5) ? (v & 3'b110) : v;
            2:       DataOut <= 3'd0;
            3:       DataOut <= ~v;
            default: DataOut <= v;
        endcase
    end

    function automatic logic [2:0] pat(input int a, input int p);
        logic [2:0] v;
        v = a[2:0];
        return (p != 0) ? ~v : v;
    endfunction

    // What the faulty RAM hands back for address a on pass p.
    function automatic logic [2:0] fault_read(input int a, input int p);
        logic [2:0] e;
        e = pat(a, p);
        case (ram_mode)
            1:       return (a == 5) ? (e & 3'b110) : e;
            2:       return 3'd0;
            3:       return ~e;
            default: return e;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 running (m_t cycles since start edge), 2 done.
    int         m_phase = 0;
    int         m_t = 0;
    int         m_err = 0;
    int         m_fe_addr = 0;
    int         m_fe_data = 0;
    int         m_fe_pass = 0;

    // Compare process: checks all DUT outputs on every falling edge, then
    // advances the model by the rising edge that follows.
    always @(negedge clk) begin
        int p, o, a;
        logic [18:0] exp_v, act_v;
        logic [4:0]  e_addr;
        logic [2:0]  e_din;
        logic        e_wr, e_busy, e_done, e_fail;
        logic [6:0]  e_err;
        if (reset) begin
            m_phase = 0; m_t = 0; m_err = 0;
            m_fe_addr = 0; m_fe_data = 0; m_fe_pass = 0;
        end
        p = m_t / PASS_LEN;
        o = m_t % PASS_LEN;
        e_addr = 5'd0; e_din = 3'd0; e_wr = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_fail = 1'b0;
        e_err  = 7'(m_err);
        if (m_phase == 1) begin
            e_busy = 1'b1;
            if (o < 32) begin
                e_addr = 5'(o);
                e_wr   = 1'b1;
                e_din  = pat(o, p);
            end else begin
                e_addr = 5'((o - 32) / (LAT + 1));
            end
        end else if (m_phase == 2) begin
            e_done = 1'b1;
            e_fail = (m_err != 0);
        end
        exp_v = {e_addr, e_din, e_wr, e_busy, e_done, e_fail, e_err};
        act_v = {Address, DataIn, Write, busy, done, fail, err_count};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_model t=%0d phase=%0d: actual addr/din/wr/busy/done/fail/err=%h required=%h",
                     m_t, m_phase, act_v, exp_v);
        end
`ifdef RAM_BIST_ERRLOG_EN
        n_cmp++;
        if ({first_err_addr, first_err_data, first_err_pass} !==
            {5'(m_fe_addr), 3'(m_fe_data), 1'(m_fe_pass)}) begin
            n_bad++;
            $display("FAIL errlog_model t=%0d: actual %h required %h", m_t,
                     {first_err_addr, first_err_data, first_err_pass},
                     {5'(m_fe_addr), 3'(m_fe_data), 1'(m_fe_pass)});
        end
`endif
        if (!reset) begin
            if (m_phase == 1) begin
                if (o >= 32 && ((o - 32) % (LAT + 1)) == LAT) begin
                    a = (o - 32) / (LAT + 1);
                    if (fault_read(a, p) != pat(a, p)) begin
                        if (m_err == 0) begin
                            m_fe_addr = a;
                            m_fe_data = int'(fault_read(a, p));
                            m_fe_pass = p;
                        end
                        if (m_err < 64) m_err++;
                    end
                end
                m_t++;
                if (m_t == 2 * PASS_LEN) m_phase = 2;
            end else if (start) begin
                m_phase = 1; m_t = 0; m_err = 0;
                m_fe_addr = 0; m_fe_data = 0; m_fe_pass = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Pulse start for one cycle, then wait for done; inject a start pulse at
    // cycle 'inject' after the start edge if inject >= 0.
    task automatic run(input int mode, input int inject, output int cyc);
        ram_mode = mode;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_err_cleared", int'(err_count), 0);
        chk("restart_done_cleared", int'(done), 0);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == inject);
        end
        start = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout mode=%0d: done never rose within %0d cycles", mode, cyc);
        end
    endtask

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_address", int'(Address), 0);
        chk("reset_write", int'(Write), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done_fail", int'({done, fail}), 0);
        chk("reset_err", int'(err_count), 0);
        @(posedge clk); #2 reset = 1'b0;

        // Fault-free, with a stray start pulse during READ of pass 0.
        run(0, 40, cyc);
        $display("run mode=0 cycles=%0d err=%0d fail=%0b", cyc, err_count, fail);
        chk("clean_cycles", cyc, 192);
        chk("clean_err", int'(err_count), 0);
        chk("clean_fail", int'(fail), 0);
        repeat (3) @(posedge clk);
        #1 chk("done_holds", int'(done), 1);

        // Stuck-at bit at address 5, restarted straight from DONE.
        run(1, -1, cyc);
        $display("run mode=1 cycles=%0d err=%0d fail=%0b", cyc, err_count, fail);
        chk("stuck_err", int'(err_count), 1);
        chk("stuck_fail", int'(fail), 1);
`ifdef RAM_BIST_ERRLOG_EN
        chk("stuck_fe_addr", int'(first_err_addr), 5);
        chk("stuck_fe_data", int'(first_err_data), 4);
        chk("stuck_fe_pass", int'(first_err_pass), 0);
`endif

        run(2, -1, cyc);
        $display("run mode=2 cycles=%0d err=%0d fail=%0b", cyc, err_count, fail);
        chk("zero_ram_err", int'(err_count), 56);
        chk("zero_ram_fail", int'(fail), 1);

        run(3, -1, cyc);
        $display("run mode=3 cycles=%0d err=%0d fail=%0b", cyc, err_count, fail);
        chk("inverted_err", int'(err_count), 64);
        chk("inverted_fail", int'(fail), 1);

        // Reset in the middle of pass-1 WRITE.
        ram_mode = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 chk("midrun_was_writing", int'(Write), 1);
        reset = 1'b1;
        #1;
        $display("midrun reset: addr=%0d din=%0d wr=%0b busy=%0b done=%0b err=%0d",
                 Address, DataIn, Write, busy, done, err_count);
        chk("midrun_reset_outputs",
            int'({Address, DataIn, Write, busy, done, fail, err_count}), 0);
        @(posedge clk); #2 reset = 1'b0;
        run(0, -1, cyc);
        $display("run after reset cycles=%0d err=%0d fail=%0b", cyc, err_count, fail);
        chk("post_reset_cycles", cyc, 192);
        chk("post_reset_err", int'(err_count), 0);
        chk("post_reset_fail", int'(fail), 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
